// File: rtl/paddle_ctrl.sv
// paddle_ctrl: accumulates move requests (mv_valid/mv_ready, mv_dx/mv_dy) and applies them clamped to x_loc/y_loc once per frame_start, pulsing update_done and flagging clamp_x/clamp_y
module paddle_ctrl #(
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 615,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 461,
  parameter int X_INIT = 308,
  parameter int Y_INIT = 230
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        mv_valid,
  output logic        mv_ready,
  input  logic [15:0] mv_dx,
  input  logic [15:0] mv_dy,
  output logic [15:0] x_loc,
  output logic [15:0] y_loc,
  output logic        update_done,
  output logic        clamp_x,
  output logic        clamp_y
);
  typedef enum logic [1:0] {IDLE, HELD, APPLY} state_t;
  localparam logic signed [17:0] X_LO = 18'(X_MIN);
  localparam logic signed [17:0] X_HI = 18'(X_MAX);
  localparam logic signed [17:0] Y_LO = 18'(Y_MIN);
  localparam logic signed [17:0] Y_HI = 18'(Y_MAX);
  state_t state, state_nxt;
  logic signed [17:0] acc_x, acc_y;
  logic [16:0] nx, ny;
  logic hs;
  function automatic logic signed [17:0] sat_add(input logic signed [17:0] a, input logic [15:0] d);
    logic signed [17:0] s;
    s = a + $signed({{2{d[15]}}, d});
    return s > 18'sd2047 ? 18'sd2047 : s < -18'sd2048 ? -18'sd2048 : s;
  endfunction
  function automatic logic [16:0] clamp(input logic [15:0] loc, input logic signed [17:0] acc,
                                        input logic signed [17:0] lo, input logic signed [17:0] hi);
    logic signed [17:0] s;
    s = $signed({2'b00, loc}) + acc;
    return s < lo ? {1'b1, lo[15:0]} : s > hi ? {1'b1, hi[15:0]} : {1'b0, s[15:0]};
  endfunction
  always_comb begin
    mv_ready  = state != APPLY && !rst;
    hs        = mv_valid && mv_ready;
    state_nxt = state == APPLY ? IDLE : state == HELD ? (frame_start ? APPLY : HELD) : (hs ? HELD : IDLE);
    nx        = clamp(x_loc, acc_x, X_LO, X_HI);
    ny        = clamp(y_loc, acc_y, Y_LO, Y_HI);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc_x       <= '0;
      acc_y       <= '0;
      x_loc       <= 16'(X_INIT);
      y_loc       <= 16'(Y_INIT);
      update_done <= 1'b0;
      clamp_x     <= 1'b0;
      clamp_y     <= 1'b0;
    end else begin
      state       <= state_nxt;
      update_done <= state == APPLY;
      if (state == APPLY) begin
        {clamp_x, x_loc} <= nx;
        {clamp_y, y_loc} <= ny;
        acc_x            <= '0;
        acc_y            <= '0;
      end else if (hs) begin
        acc_x <= sat_add(acc_x, mv_dx);
        acc_y <= sat_add(acc_y, mv_dy);
      end
    end
  end
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: table vectors, corner sequences and randomized traffic against a frame-level reference model
module tb_paddle_ctrl;
  logic clk, rst, frame_start, mv_valid, mv_ready, update_done, clamp_x, clamp_y;
  logic [15:0] mv_dx, mv_dy, x_loc, y_loc;
  int checks = 0, errors = 0;
  int m_x, m_y, m_ax, m_ay;
  bit m_pend, m_app, m_done, m_cx, m_cy;
  typedef struct {
    bit rst_before; bit v; int dx; int dy; bit fs;
    int ex; int ey; bit ed; bit ecx; bit ecy; bit erdy;
  } vec_t;
  vec_t tbl[11];
  paddle_ctrl dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_dx(mv_dx), .mv_dy(mv_dy), .x_loc(x_loc), .y_loc(y_loc), .update_done(update_done),
    .clamp_x(clamp_x), .clamp_y(clamp_y)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int sat(int v);
    return v > 2047 ? 2047 : v < -2048 ? -2048 : v;
  endfunction
  function automatic int lim(int v, int lo, int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
  task automatic model_edge();
    int sx, sy;
    if (m_app) begin
      sx = m_x + m_ax;
      sy = m_y + m_ay;
      m_cx = sx < 0 || sx > 615;
      m_cy = sy < 0 || sy > 461;
      m_x = lim(sx, 0, 615);
      m_y = lim(sy, 0, 461);
      m_ax = 0; m_ay = 0; m_app = 0; m_pend = 0; m_done = 1;
    end else begin
      m_done = 0;
      if (mv_valid) begin
        m_ax = sat(m_ax + int'($signed(mv_dx)));
        m_ay = sat(m_ay + int'($signed(mv_dy)));
      end
      if (m_pend && frame_start) m_app = 1;
      if (mv_valid) m_pend = 1;
    end
  endtask
  task automatic model_chk();
    chk("x_loc", int'(x_loc), m_x);
    chk("y_loc", int'(y_loc), m_y);
    chk("update_done", int'(update_done), int'(m_done));
    chk("clamp_x", int'(clamp_x), int'(m_cx));
    chk("clamp_y", int'(clamp_y), int'(m_cy));
    chk("mv_ready", int'(mv_ready), int'(!m_app));
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_chk();
  endtask
  task automatic drive(bit v, int dx, int dy, bit fs);
    mv_valid = v; mv_dx = 16'(dx); mv_dy = 16'(dy); frame_start = fs;
  endtask
  task automatic do_reset();
    rst = 1;
    drive(0, 0, 0, 0);
    #1;
    m_x = 308; m_y = 230; m_ax = 0; m_ay = 0;
    m_pend = 0; m_app = 0; m_done = 0; m_cx = 0; m_cy = 0;
    chk("reset_x", int'(x_loc), 308);
    chk("reset_y", int'(y_loc), 230);
    chk("reset_ready", int'(mv_ready), 0);
    chk("reset_done", int'(update_done), 0);
    chk("reset_clamp", int'({clamp_x, clamp_y}), 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    tbl[0]  = '{1, 1, 10, -5, 0, 308, 230, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 1, 308, 230, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 318, 225, 1, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 0, 318, 225, 0, 0, 0, 1};
    tbl[4]  = '{1, 1, -400, 300, 0, 308, 230, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 1, 308, 230, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 461, 1, 1, 1, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 461, 0, 1, 1, 1};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 461, 0, 1, 1, 1};
    tbl[9]  = '{0, 0, 0, 0, 1, 0, 461, 0, 1, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 461, 1, 0, 0, 1};
    rst = 0;
    drive(0, 0, 0, 0);
    #3;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_before) do_reset();
      drive(tbl[i].v, tbl[i].dx, tbl[i].dy, tbl[i].fs);
      step();
      chk($sformatf("vec%0d_x", i), int'(x_loc), tbl[i].ex);
      chk($sformatf("vec%0d_y", i), int'(y_loc), tbl[i].ey);
      chk($sformatf("vec%0d_done", i), int'(update_done), int'(tbl[i].ed));
      chk($sformatf("vec%0d_cx", i), int'(clamp_x), int'(tbl[i].ecx));
      chk($sformatf("vec%0d_cy", i), int'(clamp_y), int'(tbl[i].ecy));
      chk($sformatf("vec%0d_rdy", i), int'(mv_ready), int'(tbl[i].erdy));
    end
    do_reset();
    repeat (3) begin
      drive(1, 2000, 0, 0);
      step();
    end
    drive(0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0);
    step();
    chk("sat_x", int'(x_loc), 615);
    chk("sat_clamp_x", int'(clamp_x), 1);
    do_reset();
    drive(1, 1, 0, 1);
    step();
    drive(0, 0, 0, 0);
    step();
    chk("ignored_fs_done", int'(update_done), 0);
    drive(0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0);
    step();
    chk("late_apply_x", int'(x_loc), 309);
    chk("late_apply_done", int'(update_done), 1);
    do_reset();
    drive(1, 4, 0, 0);
    step();
    drive(1, 3, 0, 1);
    step();
    chk("apply_ready_low", int'(mv_ready), 0);
    drive(1, 100, 0, 1);
    step();
    chk("coincident_x", int'(x_loc), 315);
    step();
    drive(0, 0, 0, 0);
    step();
    chk("no_double_apply", int'(update_done), 0);
    drive(0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0);
    step();
    chk("held_request_x", int'(x_loc), 415);
    do_reset();
    drive(1, 50, 50, 0);
    step();
    drive(0, 0, 0, 0);
    do_reset();
    chk("abort_x", int'(x_loc), 308);
    drive(0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0);
    repeat (2) begin
      step();
      chk("abort_no_done", int'(update_done), 0);
    end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      drive($urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 200)) - 100,
            ($urandom_range(0, 7) == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 200)) - 100,
            $urandom_range(0, 4) == 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
